// File: rtl/uart_pkg.sv
// Shared UART definitions: conf word layout, reset configuration and the baud/bit-period table.
package uart_pkg;

    localparam int unsigned CONF_BAUD_HI  = 7;
    localparam int unsigned CONF_BAUD_LO  = 5;
    localparam int unsigned CONF_VALID_EN = 3;
    localparam int unsigned CONF_PAR_EN   = 1;
    localparam int unsigned CONF_PAR_ODD  = 0;

    // 115200 baud, valid enabled, no parity
    localparam logic [7:0] CONF_RESET = 8'hE8;

    // Clock cycles per serial bit (bp + 1) for baud index idx.
    function automatic logic [31:0] bit_cycles(input logic [31:0] freq, input logic [2:0] idx);
        case (idx)
            3'd0:    return freq / 32'd1200;
            3'd1:    return freq / 32'd2400;
            3'd2:    return freq / 32'd4800;
            3'd3:    return freq / 32'd9600;
            3'd4:    return freq / 32'd19200;
            3'd5:    return freq / 32'd38400;
            3'd6:    return freq / 32'd57600;
            default: return freq / 32'd115200;
        endcase
    endfunction

endpackage

// File: rtl/uart_ctrl_fifo.sv
// Synchronous FIFO with registered storage; the head entry is presented combinationally.
module uart_ctrl_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LEVEL_W = PTR_W + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LEVEL_W-1:0] level_q;
    logic               do_push;
    logic               do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LEVEL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = level_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: deferred conf updates, one-entry pending stage with idle-gap message
// framing, output FIFO and saturating parity/overrun counters.
module uart_rx_ctrl #(
    parameter int unsigned FREQ            = 50000000,
    parameter int unsigned UART_DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned IDLE_CHARS      = 2,
    parameter logic [7:0]  CONF_RESET      = uart_pkg::CONF_RESET
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          cfg_wr,
    input  logic [7:0]                    cfg_data,
    output logic                          cfg_busy,
    output logic [7:0]                    conf,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    input  logic [UART_DATA_WIDTH:0]      rx_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [UART_DATA_WIDTH-1:0]    m_data,
    output logic                          m_err,
    output logic                          m_last,
    input  logic                          clr_cnt,
    output logic [15:0]                   par_err_cnt,
    output logic [15:0]                   ovr_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import uart_pkg::*;

    localparam int unsigned ENTRY_W = UART_DATA_WIDTH + 2;

    localparam logic [1:0] CFG_RUN   = 2'd0;
    localparam logic [1:0] CFG_WAIT  = 2'd1;
    localparam logic [1:0] CFG_APPLY = 2'd2;

    logic [1:0]                 cfg_state_q;
    logic [7:0]                 conf_q;
    logic [7:0]                 shadow_q;
    logic [31:0]                quiet_q;
    logic [31:0]                char_cycles;
    logic [31:0]                gap_limit;

    logic                       pend_valid_q;
    logic [UART_DATA_WIDTH-1:0] pend_data_q;
    logic                       pend_err_q;
    logic [31:0]                gap_q;
    logic [15:0]                par_err_q;
    logic [15:0]                ovr_q;

    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_space;
    logic                       timeout;
    logic                       drop;
    logic [ENTRY_W-1:0]         push_entry;
    logic [ENTRY_W-1:0]         head;

    // Character time follows the live conf, so a pending change is timed at the old rate.
    assign char_cycles = bit_cycles(FREQ, conf_q[CONF_BAUD_HI:CONF_BAUD_LO])
                       * (conf_q[CONF_PAR_EN] ? 32'd11 : 32'd10);
    assign gap_limit   = char_cycles * IDLE_CHARS;

    assign conf     = conf_q;
    assign cfg_busy = (cfg_state_q != CFG_RUN);
    assign rx_ready = 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_state_q <= CFG_RUN;
            conf_q      <= CONF_RESET;
            shadow_q    <= CONF_RESET;
            quiet_q     <= '0;
        end else begin
            case (cfg_state_q)
                CFG_RUN: begin
                    if (cfg_wr) begin
                        shadow_q    <= cfg_data;
                        quiet_q     <= '0;
                        cfg_state_q <= CFG_WAIT;
                    end
                end
                CFG_WAIT: begin
                    if (!rx) begin
                        quiet_q <= '0;
                    end else begin
                        quiet_q <= quiet_q + 32'd1;
                        if (quiet_q + 32'd1 >= char_cycles) begin
                            cfg_state_q <= CFG_APPLY;
                        end
                    end
                end
                CFG_APPLY: begin
                    conf_q      <= shadow_q;
                    cfg_state_q <= CFG_RUN;
                end
                default: cfg_state_q <= CFG_RUN;
            endcase
        end
    end

    // A new byte always wins over the idle timeout; the timeout push then carries last = 0.
    assign timeout    = pend_valid_q && !rx_valid && (gap_q >= gap_limit);
    assign fifo_pop   = !fifo_empty && m_ready;
    assign fifo_space = !fifo_full || fifo_pop;
    assign fifo_push  = fifo_space && ((rx_valid && pend_valid_q) || timeout);
    assign drop       = rx_valid && pend_valid_q && !fifo_space;
    assign push_entry = {timeout, pend_err_q, pend_data_q};

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_err_q   <= 1'b0;
            gap_q        <= '0;
        end else if (rx_valid) begin
            gap_q <= '0;
            if (!drop) begin
                pend_valid_q <= 1'b1;
                pend_data_q  <= rx_data[UART_DATA_WIDTH-1:0];
                pend_err_q   <= rx_data[UART_DATA_WIDTH];
            end
        end else if (pend_valid_q) begin
            if (timeout) begin
                // A blocked timeout keeps the byte and retries every cycle.
                if (fifo_space) begin
                    pend_valid_q <= 1'b0;
                    gap_q        <= '0;
                end
            end else begin
                gap_q <= gap_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clr_cnt) begin
            par_err_q <= '0;
            ovr_q     <= '0;
        end else begin
            if (rx_valid && rx_data[UART_DATA_WIDTH] && (par_err_q != 16'hFFFF)) begin
                par_err_q <= par_err_q + 16'd1;
            end
            if (drop && (ovr_q != 16'hFFFF)) begin
                ovr_q <= ovr_q + 16'd1;
            end
        end
    end

    assign par_err_cnt = par_err_q;
    assign ovr_cnt     = ovr_q;

    uart_ctrl_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = head[UART_DATA_WIDTH-1:0];
    assign m_err   = head[UART_DATA_WIDTH];
    assign m_last  = head[UART_DATA_WIDTH+1];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl at FREQ = 1152000 (10 cycles/bit, 100-cycle character).
module tb_uart_rx_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [7:0]  cfg_data = 8'h00;
    logic        cfg_busy;
    logic [7:0]  conf;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [8:0]  rx_data = 9'h000;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_err;
    logic        m_last;
    logic        clr_cnt = 1'b0;
    logic [15:0] par_err_cnt;
    logic [15:0] ovr_cnt;
    logic [3:0]  fifo_level;

    uart_rx_ctrl #(
        .FREQ            (1152000),
        .UART_DATA_WIDTH (8),
        .FIFO_DEPTH      (8),
        .IDLE_CHARS      (2),
        .CONF_RESET      (8'hE8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .cfg_wr      (cfg_wr),
        .cfg_data    (cfg_data),
        .cfg_busy    (cfg_busy),
        .conf        (conf),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_err       (m_err),
        .m_last      (m_last),
        .clr_cnt     (clr_cnt),
        .par_err_cnt (par_err_cnt),
        .ovr_cnt     (ovr_cnt),
        .fifo_level  (fifo_level)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       last;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic e, input logic l, input int due);
        sb.push_back('{data: d, err: e, last: l, due: due});
    endtask

    // One-cycle rx_valid pulse; t is the cycle count just before the sampling edge.
    task automatic send(input logic [8:0] d, output int t);
        @(posedge clock);
        #1;
        rx_valid = 1'b1;
        rx_data  = d;
        t        = cyc;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT hands over a byte.
    always @(negedge clock) begin
        if (!reset && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data=%0h err=%0b last=%0b, required none",
                         m_data, m_err, m_last);
            end else begin
                mon_e = sb.pop_front();
                check("m_data", 32'(m_data), 32'(mon_e.data));
                check("m_err", 32'(m_err), 32'(mon_e.err));
                check("m_last", 32'(m_last), 32'(mon_e.last));
                if (mon_e.due >= 0) check("last_latency", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;

        // Reset state
        idle(3);
        reset = 1'b0;
        idle(1);
        check("reset_conf", 32'(conf), 32'hE8);
        check("reset_busy", 32'(cfg_busy), 32'h0);
        check("reset_m_valid", 32'(m_valid), 32'h0);
        check("reset_m_data", 32'({m_last, m_err, m_data}), 32'h0);
        check("reset_par_cnt", 32'(par_err_cnt), 32'h0);
        check("reset_ovr_cnt", 32'(ovr_cnt), 32'h0);
        check("reset_rx_ready", 32'(rx_ready), 32'h1);
        check("reset_level", 32'(fifo_level), 32'h0);

        // Three-byte message, closed by a 200-cycle idle gap
        m_ready = 1'b1;
        expect_byte(8'h41, 1'b0, 1'b0, -1);
        expect_byte(8'h42, 1'b0, 1'b0, -1);
        send(9'h041, t);
        idle(18);
        send(9'h042, t);
        idle(18);
        send(9'h043, t);
        expect_byte(8'h43, 1'b0, 1'b1, t + 202);
        idle(240);
        check("msg_drained", 32'(sb.size()), 32'h0);

        // Overrun: 10 bytes with the consumer stalled
        m_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            send({1'b0, 8'(8'h10 + i)}, t);
        end
        for (int i = 1; i <= 9; i++) begin
            expect_byte(8'(8'h10 + i), 1'b0, (i == 9), -1);
        end
        idle(5);
        check("ovr_level", 32'(fifo_level), 32'h8);
        check("ovr_cnt", 32'(ovr_cnt), 32'h1);
        check("ovr_head", 32'(m_data), 32'h11);
        check("ovr_m_valid", 32'(m_valid), 32'h1);
        m_ready = 1'b1;
        idle(260);
        check("ovr_drained", 32'(sb.size()), 32'h0);
        check("ovr_level_empty", 32'(fifo_level), 32'h0);

        // Parity error flagging and clear priority
        clr_cnt = 1'b1;
        idle(1);
        clr_cnt = 1'b0;
        check("clr_ovr", 32'(ovr_cnt), 32'h0);
        expect_byte(8'h55, 1'b1, 1'b0, -1);
        expect_byte(8'hAA, 1'b1, 1'b1, -1);
        send(9'h155, t);
        idle(2);
        check("par_cnt_one", 32'(par_err_cnt), 32'h1);
        rx_valid = 1'b1;
        rx_data  = 9'h1AA;
        clr_cnt  = 1'b1;
        idle(1);
        rx_valid = 1'b0;
        clr_cnt  = 1'b0;
        check("par_clr_priority", 32'(par_err_cnt), 32'h0);
        idle(240);
        check("par_drained", 32'(sb.size()), 32'h0);

        // Saturation: 65535 back-to-back parity errors, then one more
        for (int i = 0; i < 65535; i++) begin
            expect_byte(8'hC3, 1'b1, 1'b0, -1);
        end
        rx_data  = 9'h1C3;
        rx_valid = 1'b1;
        repeat (65535) @(posedge clock);
        #1;
        rx_valid = 1'b0;
        idle(3);
        check("par_cnt_full", 32'(par_err_cnt), 32'hFFFF);
        check("sat_no_ovr", 32'(ovr_cnt), 32'h0);
        expect_byte(8'hC3, 1'b1, 1'b1, -1);
        send(9'h1C3, t);
        idle(2);
        check("par_cnt_sat", 32'(par_err_cnt), 32'hFFFF);
        idle(240);
        check("sat_drained", 32'(sb.size()), 32'h0);

        // Deferred configuration change
        cfg_wr   = 1'b1;
        cfg_data = 8'h68;
        idle(1);
        cfg_wr = 1'b0;
        check("cfg_busy_set", 32'(cfg_busy), 32'h1);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                cfg_wr   = 1'b1;
                cfg_data = 8'h00;
            end
            rx = 1'b1;
            idle(1);
            cfg_wr = 1'b0;
            idle(48);
            rx = 1'b0;
            idle(1);
        end
        check("cfg_busy_held", 32'(cfg_busy), 32'h1);
        check("cfg_conf_held", 32'(conf), 32'hE8);
        rx = 1'b1;
        n  = 0;
        while (cfg_busy && n < 150) begin
            idle(1);
            n++;
        end
        check("cfg_apply_delay", n, 101);
        check("cfg_conf_new", 32'(conf), 32'h68);
        check("cfg_busy_clear", 32'(cfg_busy), 32'h0);

        // Reset mid-message discards everything
        m_ready = 1'b0;
        send(9'h101, t);
        send(9'h002, t);
        send(9'h103, t);
        idle(2);
        check("pre_reset_level", 32'(fifo_level), 32'h2);
        reset = 1'b1;
        idle(1);
        check("mid_reset_level", 32'(fifo_level), 32'h0);
        check("mid_reset_m_valid", 32'(m_valid), 32'h0);
        check("mid_reset_par", 32'(par_err_cnt), 32'h0);
        check("mid_reset_conf", 32'(conf), 32'hE8);
        reset   = 1'b0;
        m_ready = 1'b1;
        idle(250);
        check("post_reset_level", 32'(fifo_level), 32'h0);
        check("post_reset_ovr", 32'(ovr_cnt), 32'h0);
        check("final_sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
